// File: rtl/button_event_controller_if.sv
// Event output channel of button_event_controller.
//   evt_valid : event available (driven by the controller)
//   evt_ready : consumer accepts the event on a posedge where evt_valid is high
//   evt_id    : index of the button that produced the event
//   evt_type  : 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
// master = controller side, slave = consumer side.
interface button_event_controller_if #(
  parameter int N_BUTTONS = 4
);
  localparam int IW = $clog2(N_BUTTONS);

  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_id;
  logic [1:0]    evt_type;

  modport master (output evt_valid, output evt_id, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_type, output evt_ready);
endinterface

// File: rtl/button_event_controller.sv
// Turns N debounced button levels into one PRESS/RELEASE/LONG/REPEAT event
// stream. Each button lane has an edge detector, a small FSM, a hold timer
// and a one-deep pending slot; a round-robin arbiter drains the slots into
// a registered valid/ready output.
//   clk, reset     : clock, asynchronous active-high reset
//   btn_level      : debounced levels, 1 = pressed
//   evt            : event channel (master modport)
//   overflow       : sticky per button, a pending event was overwritten
//   overflow_clear : one-cycle pulse clearing every overflow bit

// Per-button lane: edge detect, press/hold FSM, timer, pending slot.
module button_event_lane #(
  parameter int LONG_PRESS_CYCLES = 8,
  parameter int REPEAT_CYCLES     = 4,
  parameter int TW                = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic       grant,
  input  logic       overflow_clear,
  output logic       slot_full,
  output logic [1:0] slot_type,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_PRESS_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? TW'(REPEAT_CYCLES - 1) : '0;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          btn_q;
  logic          rise, fall;
  logic          post;
  logic [1:0]    post_type;
  logic          slot_full_n;
  logic [1:0]    slot_type_n;
  logic          overflow_n;

  assign rise = level & ~btn_q;
  assign fall = ~level & btn_q;

  // Falls are checked before timer expiry so a release always wins.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    post      = 1'b0;
    post_type = EVT_PRESS;
    unique case (state)
      IDLE: begin
        if (rise) begin
          post      = 1'b1;
          post_type = EVT_PRESS;
          timer_n   = '0;
          state_n   = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EVT_RELEASE;
          timer_n   = '0;
          state_n   = IDLE;
        end else if (timer == LONG_LAST) begin
          post      = 1'b1;
          post_type = EVT_LONG;
          timer_n   = '0;
          state_n   = HELD;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EVT_RELEASE;
          timer_n   = '0;
          state_n   = IDLE;
        end else if (REPEAT_CYCLES > 0) begin
          if (timer == REP_LAST) begin
            post      = 1'b1;
            post_type = EVT_REPEAT;
            timer_n   = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // A post on the same edge as a grant refills the slot without overflow.
  always_comb begin
    slot_full_n = slot_full;
    slot_type_n = slot_type;
    if (grant) slot_full_n = 1'b0;
    if (post) begin
      slot_full_n = 1'b1;
      slot_type_n = post_type;
    end
    if (overflow_clear)                   overflow_n = 1'b0;
    else if (post && slot_full && !grant) overflow_n = 1'b1;
    else                                  overflow_n = overflow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      btn_q     <= 1'b0;
      slot_full <= 1'b0;
      slot_type <= EVT_PRESS;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      btn_q     <= level;
      slot_full <= slot_full_n;
      slot_type <= slot_type_n;
      overflow  <= overflow_n;
    end
  end
endmodule

module button_event_controller #(
  parameter int N_BUTTONS         = 4,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_BUTTONS-1:0]    btn_level,
  button_event_controller_if.master evt,
  output logic [N_BUTTONS-1:0]    overflow,
  input  logic                    overflow_clear
);
  localparam int IW   = $clog2(N_BUTTONS);
  localparam int TMAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  logic [N_BUTTONS-1:0]      slot_full;
  logic [N_BUTTONS-1:0][1:0] slot_type;
  logic [N_BUTTONS-1:0]      grant;
  logic [IW-1:0]             rr_ptr, winner;
  logic                      any_full;
  logic                      load;
  int                        idx;
  logic                      valid_q;
  logic [IW-1:0]             id_q;
  logic [1:0]                type_q;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_lane
    button_event_lane #(
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES),
      .TW               (TW)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .level         (btn_level[i]),
      .grant         (grant[i]),
      .overflow_clear(overflow_clear),
      .slot_full     (slot_full[i]),
      .slot_type     (slot_type[i]),
      .overflow      (overflow[i])
    );
  end

  // First full slot scanning upward from rr_ptr. Slots are registered, so a
  // slot posted on this edge only becomes visible here on the next one.
  always_comb begin
    winner   = '0;
    any_full = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      idx = (int'(rr_ptr) + k) % N_BUTTONS;
      if (!any_full && slot_full[IW'(idx)]) begin
        any_full = 1'b1;
        winner   = IW'(idx);
      end
    end
  end

  // Output stage refills when empty or when its event is being accepted.
  assign load = !valid_q || evt.evt_ready;

  always_comb begin
    grant = '0;
    if (load && any_full) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      type_q  <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      valid_q <= any_full;
      if (any_full) begin
        id_q   <= winner;
        type_q <= slot_type[winner];
        rr_ptr <= (winner == IW'(N_BUTTONS - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign evt.evt_type  = type_q;
endmodule

// File: tb/tb_button_event_controller.sv
// Bench for button_event_controller. Two instances share all stimulus:
// dut_a with REPEAT_CYCLES=4, dut_b with REPEAT_CYCLES=0. A behavioural
// model derives events from time-since-press arithmetic and tracks slots,
// the round-robin pointer and the output stage per clock edge.
module tb_button_event_controller;
  localparam int N = 4;
  localparam int L = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_level = '0;
  logic         evt_ready = 1'b1;
  logic         overflow_clear = 1'b0;
  logic [N-1:0] ovf_a, ovf_b;
  int           checks = 0;
  int           errors = 0;

  button_event_controller_if #(.N_BUTTONS(N)) ev_a ();
  button_event_controller_if #(.N_BUTTONS(N)) ev_b ();
  assign ev_a.evt_ready = evt_ready;
  assign ev_b.evt_ready = evt_ready;

  button_event_controller #(.N_BUTTONS(N), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R)) dut_a (
    .clk(clk), .reset(reset), .btn_level(btn_level), .evt(ev_a),
    .overflow(ovf_a), .overflow_clear(overflow_clear));

  button_event_controller #(.N_BUTTONS(N), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .btn_level(btn_level), .evt(ev_b),
    .overflow(ovf_b), .overflow_clear(overflow_clear));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int rep_per[2];
  bit m_prev[2][N];
  bit m_held[2][N];
  int m_age [2][N];
  bit m_pv  [2][N];
  int m_pt  [2][N];
  bit m_ovf [2][N];
  bit m_ov  [2];
  int m_oid [2];
  int m_otype[2];
  int m_ptr [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ov[m] = 0; m_oid[m] = 0; m_otype[m] = 0; m_ptr[m] = 0;
      for (int i = 0; i < N; i++) begin
        m_prev[m][i] = 0; m_held[m][i] = 0; m_age[m][i] = 0;
        m_pv[m][i] = 0; m_pt[m][i] = 0; m_ovf[m][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit load;
      int win;
      int wtype;
      load = !m_ov[m] || evt_ready;
      win = -1;
      wtype = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr[m] + k) % N;
        if (win < 0 && m_pv[m][j]) begin win = j; wtype = m_pt[m][j]; end
      end
      for (int i = 0; i < N; i++) begin
        bit post;
        bit granted;
        int typ;
        post = 0; typ = 0;
        if (btn_level[i] && !m_prev[m][i]) begin
          post = 1; typ = 0; m_held[m][i] = 1; m_age[m][i] = 0;
        end else if (m_held[m][i] && !btn_level[i]) begin
          post = 1; typ = 1; m_held[m][i] = 0;
        end else if (m_held[m][i]) begin
          m_age[m][i]++;
          if (m_age[m][i] == L) begin
            post = 1; typ = 2;
          end else if (rep_per[m] > 0 && m_age[m][i] > L && (m_age[m][i] - L) % rep_per[m] == 0) begin
            post = 1; typ = 3;
          end
        end
        granted = load && (win == i);
        if (overflow_clear) m_ovf[m][i] = 0;
        else if (post && m_pv[m][i] && !granted) m_ovf[m][i] = 1;
        if (post) begin m_pv[m][i] = 1; m_pt[m][i] = typ; end
        else if (granted) m_pv[m][i] = 0;
        m_prev[m][i] = btn_level[i];
      end
      if (load) begin
        m_ov[m] = (win >= 0);
        if (win >= 0) begin m_oid[m] = win; m_otype[m] = wtype; m_ptr[m] = (win + 1) % N; end
      end
    end
  endtask

  // {valid, id, type, overflow}; id/type only meaningful while valid.
  function automatic logic [8:0] model_vec(int m);
    logic [3:0] o;
    logic [1:0] id, ty;
    for (int i = 0; i < N; i++) o[i] = m_ovf[m][i];
    id = m_ov[m] ? 2'(m_oid[m]) : 2'b0;
    ty = m_ov[m] ? 2'(m_otype[m]) : 2'b0;
    return {m_ov[m], id, ty, o};
  endfunction

  function automatic logic [8:0] dut_vec(int m);
    logic v;
    logic [1:0] id, ty;
    logic [3:0] o;
    if (m == 0) begin v = ev_a.evt_valid; id = ev_a.evt_id; ty = ev_a.evt_type; o = ovf_a; end
    else        begin v = ev_b.evt_valid; id = ev_b.evt_id; ty = ev_b.evt_type; o = ovf_b; end
    if (!v) begin id = 2'b0; ty = 2'b0; end
    return {v, id, ty, o};
  endfunction

  // Model advances with the inputs held for this edge; DUT sampled 1ns later.
  task automatic tick();
    if (reset) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_level = '0; evt_ready = 1'b1; overflow_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; btn_level = 4'b1010;
    tick(); tick();
    checks++;
    if ({ev_a.evt_valid, ev_a.evt_id, ev_a.evt_type, ovf_a} !== 9'b0) begin
      errors++; $display("FAIL reset_a got %b expected 0", {ev_a.evt_valid, ev_a.evt_id, ev_a.evt_type, ovf_a});
    end
    checks++;
    if ({ev_b.evt_valid, ev_b.evt_id, ev_b.evt_type, ovf_b} !== 9'b0) begin
      errors++; $display("FAIL reset_b got %b expected 0", {ev_b.evt_valid, ev_b.evt_id, ev_b.evt_type, ovf_b});
    end
    btn_level = '0;
    reset = 1'b0;
  endtask

  task automatic test_press_release();
    int press_at = -1;
    int n_long = 0;
    int n_rel = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      btn_level = (c < 3) ? 4'b0010 : 4'b0000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== model_vec(m)) begin
          errors++; $display("FAIL press_release dut%0d c=%0d got %b expected %b", m, c, dut_vec(m), model_vec(m));
        end
      end
      if (press_at < 0 && ev_a.evt_valid && ev_a.evt_id == 1 && ev_a.evt_type == 0) press_at = c;
      if (ev_a.evt_valid && ev_a.evt_type == 2) n_long++;
      if (ev_a.evt_valid && ev_a.evt_id == 1 && ev_a.evt_type == 1) n_rel++;
    end
    checks++;
    if (press_at !== 1) begin errors++; $display("FAIL press_latency got %0d expected 1", press_at); end
    checks++;
    if (n_long !== 0 || n_rel !== 1) begin errors++; $display("FAIL press_release_count long=%0d rel=%0d expected 0 1", n_long, n_rel); end
    checks++;
    if (ovf_a !== 4'b0) begin errors++; $display("FAIL press_release_ovf got %b expected 0000", ovf_a); end
  endtask

  task automatic test_long_repeat(input int btn, input int hold, input string exp_a, input string exp_b);
    string sa = "";
    string sb = "";
    int long_at = -1;
    do_reset();
    for (int c = 0; c < hold + 6; c++) begin
      btn_level = '0;
      if (c < hold) btn_level[btn] = 1'b1;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== model_vec(m)) begin
          errors++; $display("FAIL long_repeat dut%0d c=%0d got %b expected %b", m, c, dut_vec(m), model_vec(m));
        end
      end
      if (ev_a.evt_valid) sa = $sformatf("%s%0d", sa, ev_a.evt_type);
      if (ev_b.evt_valid) sb = $sformatf("%s%0d", sb, ev_b.evt_type);
      if (long_at < 0 && ev_a.evt_valid && ev_a.evt_type == 2) long_at = c;
    end
    checks++;
    if (sa != exp_a) begin errors++; $display("FAIL long_repeat_seq_a got %s expected %s", sa, exp_a); end
    checks++;
    if (sb != exp_b) begin errors++; $display("FAIL long_repeat_seq_b got %s expected %s", sb, exp_b); end
    checks++;
    if (long_at !== L + 1) begin errors++; $display("FAIL long_timing got %0d expected %0d", long_at, L + 1); end
  endtask

  task automatic test_arbitration();
    logic [3:0] pat [5] = '{4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b1001};
    int         len [5] = '{4, 4, 3, 3, 4};
    string s = "";
    int c = 0;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int t = 0; t < len[p]; t++) begin
        btn_level = pat[p];
        tick();
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (dut_vec(m) !== model_vec(m)) begin
            errors++; $display("FAIL arbitration dut%0d c=%0d got %b expected %b", m, c, dut_vec(m), model_vec(m));
          end
        end
        if (ev_a.evt_valid) s = $sformatf("%s%0d%0d ", s, ev_a.evt_id, ev_a.evt_type);
        c++;
      end
    end
    checks++;
    if (s != "00 30 01 31 00 01 30 00 ") begin
      errors++; $display("FAIL arbitration_order got '%s' expected '00 30 01 31 00 01 30 00 '", s);
    end
  endtask

  task automatic test_overflow();
    string s = "";
    do_reset();
    evt_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      btn_level[0] = (c < 2 || (c >= 4 && c < 10));
      if (c == 8) evt_ready = 1'b1;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== model_vec(m)) begin
          errors++; $display("FAIL overflow dut%0d c=%0d got %b expected %b", m, c, dut_vec(m), model_vec(m));
        end
      end
      if (c >= 1 && c < 8) begin
        checks++;
        if ({ev_a.evt_valid, ev_a.evt_id, ev_a.evt_type} !== 5'b10000) begin
          errors++; $display("FAIL overflow_hold c=%0d got %b expected 10000", c, {ev_a.evt_valid, ev_a.evt_id, ev_a.evt_type});
        end
      end
      if (c == 7) begin
        checks++;
        if (ovf_a !== 4'b0001) begin errors++; $display("FAIL overflow_set got %b expected 0001", ovf_a); end
      end
      if (c >= 7 && ev_a.evt_valid) s = $sformatf("%s%0d", s, ev_a.evt_type);
    end
    checks++;
    if (s != "001") begin errors++; $display("FAIL overflow_drain got %s expected 001", s); end
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    checks++;
    if (ovf_a !== 4'b0 || ovf_b !== 4'b0) begin
      errors++; $display("FAIL overflow_clear got %b %b expected 0000 0000", ovf_a, ovf_b);
    end
  endtask

  task automatic test_async_reset();
    int press_at = -1;
    int long_at = -1;
    do_reset();
    evt_ready = 1'b0;
    btn_level = 4'b0100;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (ev_a.evt_valid !== 1'b1) begin errors++; $display("FAIL async_pre got valid=%b expected 1", ev_a.evt_valid); end
    reset = 1'b1;
    evt_ready = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ev_a.evt_valid !== 1'b0 || ev_b.evt_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got %b %b expected 0 0", ev_a.evt_valid, ev_b.evt_valid);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== model_vec(m)) begin
          errors++; $display("FAIL async_after dut%0d c=%0d got %b expected %b", m, c, dut_vec(m), model_vec(m));
        end
      end
      if (press_at < 0 && ev_a.evt_valid && ev_a.evt_type == 0) press_at = c;
      if (long_at < 0 && ev_a.evt_valid && ev_a.evt_type == 2) long_at = c;
    end
    checks++;
    if (press_at !== 1 || long_at !== L + 1) begin
      errors++; $display("FAIL async_repress got press=%0d long=%0d expected 1 %0d", press_at, long_at, L + 1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) btn_level[i] = ~btn_level[i];
      evt_ready      = ($urandom_range(0, 3) != 0);
      overflow_clear = ($urandom_range(0, 24) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== model_vec(m)) begin
          errors++; $display("FAIL random dut%0d c=%0d got %b expected %b", m, c, dut_vec(m), model_vec(m));
        end
      end
    end
    overflow_clear = 1'b0;
  endtask

  initial begin
    rep_per[0] = R;
    rep_per[1] = 0;
    model_reset();
    test_reset();
    test_press_release();
    // Held 20: PRESS, LONG@8, REPEAT@12,16, fall at 20 wins over the third.
    test_long_repeat(2, 20, "02331", "021");
    test_arbitration();
    test_overflow();
    test_async_reset();
    test_long_repeat(3, 25, "0233331", "021");
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
